dual_core_bus_arbiter: RTL and testbench
========================================

Name: dual_core_bus_arbiter

Overview:
- Arbitrates the two CPU cores' access to the single shared gpiomem port.
- Sits between core0/core1 and gpiomem inside top.
- Round-robin grant with bounded tenure (forced preemption) and a one-cycle turnaround gap between owners.
- Muxes the owning core's address/data/rw onto the memory port; returns read data only to the owner.

Parameters:
- ADDR_W, 9, address width (gpiomem space)
- DATA_W, 8, data width
- MAX_HOLD, 16, max consecutive grant cycles while the other core is requesting; 0 disables preemption
- CNT_W, 5, tenure counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
- clk, in, 1, system clock; all state on rising edge
- reset, in, 1, asynchronous, active-low reset
- req0, in, 1, core0 bus request; level, held for the whole transaction sequence
- addr0, in, ADDR_W, core0 address
- wdata0, in, DATA_W, core0 write data
- rw0, in, 1, core0 direction: 1=write, 0=read
- gnt0, out, 1, core0 owns the bus (registered)
- rdata0, out, DATA_W, read data to core0
- req1, in, 1, core1 bus request
- addr1, in, ADDR_W, core1 address
- wdata1, in, DATA_W, core1 write data
- rw1, in, 1, core1 direction
- gnt1, out, 1, core1 owns the bus (registered)
- rdata1, out, DATA_W, read data to core1
- ram_addr, out, ADDR_W, address to gpiomem
- ram_wdata, out, DATA_W, write data to gpiomem
- ram_rw, out, 1, write strobe/direction to gpiomem
- ram_rdata, in, DATA_W, read data from gpiomem
- owner, out, 2, 00=none, 01=core0, 10=core1

Behaviour:
- States: IDLE, GNT0, GNT1, TURN.
- Reset (reset=0, asynchronous):
  - State forced to IDLE.
  - gnt0=gnt1=0, owner=00, hold_cnt=0.
  - last_owner=1, so core0 wins the first tie.
  - ram_addr=0, ram_wdata=0, ram_rw=0, rdata0=rdata1=0.
  - Reset asserted mid-grant drops the grant immediately, with no turnaround cycle.
- IDLE and TURN exit arbitration, evaluated on requests sampled at the clock edge:
  - Only req0 high → GNT0.
  - Only req1 high → GNT1.
  - Both high → grant to the core that is not last_owner.
  - Neither high → IDLE.
- Grant latency:
  - gnt rises on the edge after req is first sampled high from IDLE: 1 cycle.
  - From TURN it rises on the edge ending TURN.
- GNTx:
  - gntx=1, owner reflects x.
  - ram_addr/ram_wdata/ram_rw combinationally follow addrx/wdatax/rwx.
  - rdatax=ram_rdata; the other core's rdata=0.
  - hold_cnt increments each cycle, saturating at 2^CNT_W-1.
- GNTx exits:
  - reqx sampled low → TURN.
  - MAX_HOLD≠0, hold_cnt==MAX_HOLD-1 and the other req high → TURN (preempt).
  - Release takes priority when both conditions hold on the same edge.
  - Otherwise stay in GNTx.
  - On entering TURN: last_owner←x, hold_cnt←0.
- TURN:
  - Lasts exactly 1 cycle: gnt0=gnt1=0, owner=00.
  - ram_rw forced 0; ram_addr/ram_wdata hold their last values.
- No grant (IDLE/TURN/reset):
  - ram_rw=0, so a core's rw=1 without its gnt never writes.
  - rdata0=rdata1=0.
- A core may not deassert req while its rw=1 on the same cycle it expects a write to land. Writes land on every grant cycle with rw=1.
- Preempted core keeps req high and is re-granted after the other core's tenure (round-robin), with no starvation.
- Never gnt0&gnt1 simultaneously; owner is one-hot or zero at all times.

Test Plan:
- Reset release, req0=1 only, addr0=0x10, rw0=1, wdata0=0xA5 → gnt0=1 one cycle later; ram_addr=0x10, ram_rw=1, ram_wdata=0xA5; gnt1=0, owner=01.
- req0 and req1 rise together after reset → core0 granted first. core0 drops req after 3 cycles → 1 TURN cycle with both gnts 0 and ram_rw=0, then gnt1=1, owner=10.
- MAX_HOLD=4, both requests held continuously → grant pattern 0,0,0,0,TURN,1,1,1,1,TURN,0… repeating; never both gnts high.
- MAX_HOLD=0, req0 held 50 cycles with req1 high → gnt0 stays high all 50 cycles; gnt1 is granted only after req0 falls plus 1 TURN cycle.
- core1 drives rw1=1, addr1=0x1FF while only core0 is granted → ram_rw/ram_addr reflect core0 only; rdata1=0, rdata0=ram_rdata (e.g. 0x3C).
- reset pulled low mid-GNT1 → gnt1, owner and ram_rw go to 0 asynchronously. After release with both reqs high → core0 granted first.

Source files
------------

// File: rtl/dual_core_bus_arbiter.sv
// dual_core_bus_arbiter
//   Shares the single gpiomem port between core0 and core1. Grants are
//   round-robin on ties, tenure is bounded by MAX_HOLD while the other core
//   is waiting, and every change of owner passes through a one-cycle TURN
//   gap during which nothing is driven onto the memory port.
//
//   Handshake: a core raises reqN and holds it for its whole transaction
//   sequence; gntN is high on exactly the cycles that core owns the port,
//   and each such cycle with rwN=1 is a write that lands in gpiomem. gntN
//   low means the core's addr/wdata/rw are ignored and rdataN reads 0.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   req0/addr0/wdata0/rw0 core0 request, address, write data, 1=write
//   gnt0/rdata0           core0 grant (state decode), read data
//   req1/addr1/wdata1/rw1 core1 request, address, write data, 1=write
//   gnt1/rdata1           core1 grant (state decode), read data
//   ram_addr/ram_wdata    memory address / write data (owner's, else held)
//   ram_rw                memory write strobe, 0 whenever nobody owns
//   ram_rdata             memory read data
//   owner                 00 none, 01 core0, 10 core1
//   fsm_state             arbiter state for observation (IDLE/GNT0/GNT1/TURN)
//
//   CNT_W must satisfy 2**CNT_W > MAX_HOLD so the preemption compare is
//   reachable before the tenure counter saturates.

module dual_core_bus_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              rw0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rw1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
    // Tenure ends after MAX_HOLD grant cycles: the counter reads 0 on the
    // first grant cycle, so the last allowed cycle shows MAX_HOLD-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;  // 0 = core0, 1 = core1
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  hold_cnt_inc;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;
    logic              preempt0, preempt1;

    assign hold_cnt_inc = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
    assign preempt0     = PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && req1;
    assign preempt1     = PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && req0;
    assign fsm_state    = state_q;

    // Next-state, tenure counter and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = '0;
        case (state_q)
            IDLE, TURN: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                hold_cnt_d = hold_cnt_inc;
                // Release and preemption both lead to TURN with the same
                // bookkeeping, so one branch covers either cause.
                if (!req0 || preempt0) begin
                    state_d      = TURN;
                    last_owner_d = 1'b0;
                    hold_cnt_d   = '0;
                end
            end
            GNT1: begin
                hold_cnt_d = hold_cnt_inc;
                if (!req1 || preempt1) begin
                    state_d      = TURN;
                    last_owner_d = 1'b1;
                    hold_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            // Remember the last owner's address/data so the memory port
            // stays stable through TURN and IDLE.
            if (state_q == GNT0 || state_q == GNT1) begin
                addr_hold_q  <= ram_addr;
                wdata_hold_q <= ram_wdata;
            end
        end
    end

    // Port mux: only the owner reaches gpiomem and only the owner sees data.
    always_comb begin
        gnt0      = (state_q == GNT0);
        gnt1      = (state_q == GNT1);
        owner     = {gnt1, gnt0};
        ram_addr  = addr_hold_q;
        ram_wdata = wdata_hold_q;
        ram_rw    = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        case (state_q)
            GNT0: begin
                ram_addr  = addr0;
                ram_wdata = wdata0;
                ram_rw    = rw0;
                rdata0    = ram_rdata;
            end
            GNT1: begin
                ram_addr  = addr1;
                ram_wdata = wdata1;
                ram_rw    = rw1;
                rdata1    = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dual_core_bus_arbiter.sv
// Testbench for dual_core_bus_arbiter. Two instances share one set of
// stimulus: dut_a uses MAX_HOLD=4, dut_b disables preemption. Each vector
// pushes the hand-derived expected outputs (tagged with the instance to
// check) into exp_q; the monitor pops one entry per falling clock edge.

module tb_dual_core_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, rw0, req1, rw1;
    logic [8:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, ram_rdata;

    logic       a_gnt0, a_gnt1, a_ram_rw, b_gnt0, b_gnt1, b_ram_rw;
    logic [7:0] a_rdata0, a_rdata1, a_ram_wdata, b_rdata0, b_rdata1, b_ram_wdata;
    logic [8:0] a_ram_addr, b_ram_addr;
    logic [1:0] a_owner, b_owner, a_state, b_state;

    logic [38:0] exp_q[$];
    int          vec_cnt  = 0;
    int          miss_cnt = 0;

    always #5 clk = ~clk;

    dual_core_bus_arbiter #(.ADDR_W(9), .DATA_W(8), .MAX_HOLD(4), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .rw0(rw0), .gnt0(a_gnt0), .rdata0(a_rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .rw1(rw1), .gnt1(a_gnt1), .rdata1(a_rdata1),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rw(a_ram_rw), .ram_rdata(ram_rdata),
        .owner(a_owner), .fsm_state(a_state)
    );

    dual_core_bus_arbiter #(.ADDR_W(9), .DATA_W(8), .MAX_HOLD(0), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .rw0(rw0), .gnt0(b_gnt0), .rdata0(b_rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .rw1(rw1), .gnt1(b_gnt1), .rdata1(b_rdata1),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rw(b_ram_rw), .ram_rdata(ram_rdata),
        .owner(b_owner), .fsm_state(b_state)
    );

    logic [37:0] a_act, b_act;
    assign a_act = {a_gnt0, a_gnt1, a_owner, a_ram_addr, a_ram_wdata, a_ram_rw, a_rdata0, a_rdata1};
    assign b_act = {b_gnt0, b_gnt1, b_owner, b_ram_addr, b_ram_wdata, b_ram_rw, b_rdata0, b_rdata1};

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r0, input logic [8:0] a0, input logic [7:0] w0, input logic w_rw0,
                         input logic r1, input logic [8:0] a1, input logic [7:0] w1, input logic w_rw1,
                         input logic [7:0] rd);
        req0 = r0; addr0 = a0; wdata0 = w0; rw0 = w_rw0;
        req1 = r1; addr1 = a1; wdata1 = w1; rw1 = w_rw1;
        ram_rdata = rd;
    endtask

    // Push the outputs expected at this cycle's falling edge, then advance
    // to just after the next rising edge.
    task automatic step(input logic sel, input logic g0, input logic g1, input logic [1:0] own,
                        input logic [8:0] a, input logic [7:0] w, input logic rw,
                        input logic [7:0] r0v, input logic [7:0] r1v);
        exp_q.push_back({sel, g0, g1, own, a, w, rw, r0v, r1v});
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g0(input logic sel);
        step(sel, 1'b1, 1'b0, 2'b01, addr0, wdata0, rw0, ram_rdata, 8'h00);
    endtask

    task automatic exp_g1(input logic sel);
        step(sel, 1'b0, 1'b1, 2'b10, addr1, wdata1, rw1, 8'h00, ram_rdata);
    endtask

    // No owner: strobe and read data zero, address/data held.
    task automatic exp_none(input logic sel, input logic [8:0] a, input logic [7:0] w);
        step(sel, 1'b0, 1'b0, 2'b00, a, w, 1'b0, 8'h00, 8'h00);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [38:0] e;
        logic [37:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = e[38] ? b_act : a_act;
                vec_cnt++;
                if (act !== e[37:0]) begin
                    miss_cnt++;
                    $display("FAIL vec%0d dut_%s state=%0d got={g0 g1 own addr wd rw rd0 rd1}=%b %b %b %h %h %b %h %h exp=%b %b %b %h %h %b %h %h",
                             vec_cnt, e[38] ? "b" : "a", e[38] ? b_state : a_state,
                             act[37], act[36], act[35:34], act[33:25], act[24:17], act[16], act[15:8], act[7:0],
                             e[37], e[36], e[35:34], e[33:25], e[24:17], e[16], e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int pat[15];
        int prev;

        reset = 1'b0;
        drive(0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00);
        @(posedge clk);
        #1;

        // Reset state, then a single write from core0.
        exp_none(0, 9'h000, 8'h00);
        reset = 1'b1;
        drive(1, 9'h010, 8'hA5, 1, 0, 9'h000, 8'h00, 0, 8'h3C);
        exp_none(0, 9'h000, 8'h00);                      // IDLE, rw0 without grant
        exp_g0(0);                                       // gnt0 one cycle later
        drive(0, 9'h010, 8'hA5, 0, 0, 9'h000, 8'h00, 0, 8'h3C);
        exp_g0(0);                                       // req0 low not yet sampled
        exp_none(0, 9'h010, 8'hA5);                      // TURN holds addr/data
        exp_none(0, 9'h010, 8'hA5);                      // IDLE holds addr/data

        // Simultaneous requests after reset: core0 first, 3-cycle tenure.
        reset = 1'b0;
        drive(0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00);
        exp_none(0, 9'h000, 8'h00);
        reset = 1'b1;
        drive(1, 9'h020, 8'h11, 1, 1, 9'h030, 8'h22, 1, 8'h55);
        exp_none(0, 9'h000, 8'h00);
        exp_g0(0);
        exp_g0(0);
        drive(0, 9'h020, 8'h11, 0, 1, 9'h030, 8'h22, 1, 8'h55);
        exp_g0(0);
        exp_none(0, 9'h020, 8'h11);                      // turnaround
        drive(1, 9'h020, 8'h11, 1, 1, 9'h030, 8'h22, 1, 8'h55);
        exp_g1(0);                                       // first core1 cycle

        // Both held: core1 finishes 4 cycles, then 4/TURN/4 alternation.
        pat = '{2, 2, 2, 0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1};
        prev = 2;
        for (int i = 0; i < 15; i++) begin
            case (pat[i])
                1: exp_g0(0);
                2: exp_g1(0);
                default: begin
                    if (prev == 1) exp_none(0, 9'h020, 8'h11);
                    else           exp_none(0, 9'h030, 8'h22);
                end
            endcase
            prev = pat[i];
        end

        // core1 drives a write to 0x1FF while only core0 is granted.
        reset = 1'b0;
        drive(0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00);
        exp_none(0, 9'h000, 8'h00);
        reset = 1'b1;
        drive(1, 9'h044, 8'h99, 1, 0, 9'h1FF, 8'h77, 1, 8'h3C);
        exp_none(0, 9'h000, 8'h00);
        exp_g0(0);
        exp_g0(0);
        drive(0, 9'h044, 8'h99, 0, 0, 9'h1FF, 8'h77, 1, 8'h3C);
        exp_g0(0);
        exp_none(0, 9'h044, 8'h99);

        // Reset mid-GNT1 drops everything without a clock edge.
        drive(0, 9'h044, 8'h99, 0, 1, 9'h1A0, 8'h5A, 1, 8'h3C);
        exp_none(0, 9'h044, 8'h99);
        exp_g1(0);
        reset = 1'b0;
        exp_none(0, 9'h000, 8'h00);
        reset = 1'b1;
        drive(1, 9'h021, 8'h31, 1, 1, 9'h1A0, 8'h5A, 1, 8'h3C);
        exp_none(0, 9'h000, 8'h00);
        exp_g0(0);                                       // core0 wins after reset

        // Preemption disabled: core0 keeps the bus for all 50 cycles.
        reset = 1'b0;
        drive(0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00);
        exp_none(1, 9'h000, 8'h00);
        reset = 1'b1;
        drive(1, 9'h00C, 8'hC3, 1, 1, 9'h00D, 8'hD4, 1, 8'h66);
        exp_none(1, 9'h000, 8'h00);
        for (int i = 0; i < 49; i++) exp_g0(1);
        drive(0, 9'h00C, 8'hC3, 0, 1, 9'h00D, 8'hD4, 1, 8'h66);
        exp_g0(1);
        exp_none(1, 9'h00C, 8'hC3);
        exp_g1(1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miss_cnt++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
